// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: register offsets, bit indices and serializer states shared by the UART TX target
package uart_tx_pkg;
    localparam logic [3:0] OFF_TXDATA  = 4'h0;
    localparam logic [3:0] OFF_STATUS  = 4'h4;
    localparam logic [3:0] OFF_DIVISOR = 4'h8;
    localparam logic [3:0] OFF_CTRL    = 4'hC;
    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;
    localparam int CTRL_TX_EN   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_OVF_CLR = 2;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous first-word-fall-through FIFO; pushes when full and pops when empty are ignored
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    assign full = cnt_q == DEPTH[AW:0];
    assign empty = cnt_q == '0;
    assign level = cnt_q;
    assign dout = mem_q[rd_q];
    assign do_push = push & !full;
    assign do_pop = pop & !empty;
    always_comb begin
        wr_d = wr_q + AW'(do_push);
        rd_d = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx_target.sv
// uart_tx_target: memory-mapped 8N1 UART transmitter with TX FIFO, divisor, control and status registers
module uart_tx_target import uart_tx_pkg::*; #(
    parameter logic [15:0] BASE_ADDR   = 16'hF000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wen,
    input  logic        ren,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        tx,
    output logic        irq
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    logic [3:0] off;
    logic wr, push, pop, full, empty, start_ok, bit_end;
    logic [7:0] dout;
    logic [LW-1:0] level;
    state_e state_q, state_d;
    logic [15:0] timer_q, timer_d, div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic tx_q, tx_d, irq_q, irq_d, ovf_q, ovf_d;
    assign sel = addr[15:4] == BASE_ADDR[15:4];
    assign off = addr[3:0];
    assign wr = wen & sel & (addr[1:0] == 2'b00);
    assign push = wr & (off == OFF_TXDATA);
    assign start_ok = ctrl_q[CTRL_TX_EN] & !empty;
    assign bit_end = (state_q != IDLE) & (timer_q == '0);
    assign tx = tx_q;
    assign irq = irq_q;
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(wdata[7:0]),
        .dout(dout), .full(full), .empty(empty), .level(level)
    );
    always_comb begin
        div_d = (wr && off == OFF_DIVISOR) ? wdata[15:0] : div_q;
        ctrl_d = (wr && off == OFF_CTRL) ? wdata[1:0] : ctrl_q;
        ovf_d = (push & full) | (ovf_q & !(wr && off == OFF_CTRL && wdata[CTRL_OVF_CLR]));
        irq_d = ctrl_q[CTRL_IRQ_EN] & empty & (state_q == IDLE);
    end
    always_comb begin
        state_d = state_q;
        timer_d = (state_q == IDLE) ? timer_q : (bit_end ? div_q : timer_q - 16'd1);
        bit_d = bit_q;
        shift_d = shift_q;
        tx_d = tx_q;
        pop = 1'b0;
        if (bit_end) begin
            case (state_q)
                START: begin
                    state_d = DATA;
                    tx_d = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d = 3'd0;
                end
                DATA: begin
                    state_d = (bit_q == 3'd7) ? STOP : DATA;
                    tx_d = (bit_q == 3'd7) ? 1'b1 : shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d = bit_q + 3'd1;
                end
                default: state_d = IDLE;
            endcase
        end
        // A finishing stop bit chains straight into the next start bit
        if (start_ok && (state_q == IDLE || (state_q == STOP && bit_end))) begin
            pop = 1'b1;
            shift_d = dout;
            tx_d = 1'b0;
            state_d = START;
            timer_d = div_q;
        end
    end
    always_comb begin
        rdata = '0;
        if (sel && ren && addr[1:0] == 2'b00)
            rdata = (off == OFF_STATUS)  ? {16'h0, 8'(level), 4'h0, ovf_q, empty, full, state_q != IDLE} :
                    (off == OFF_DIVISOR) ? {16'h0, div_q} :
                    (off == OFF_CTRL)    ? {30'h0, ctrl_q} : 32'h0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            tx_q <= 1'b1;
            irq_q <= 1'b0;
            ovf_q <= 1'b0;
            div_q <= DEFAULT_DIV;
            ctrl_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            tx_q <= tx_d;
            irq_q <= irq_d;
            ovf_q <= ovf_d;
            div_q <= div_d;
            ctrl_q <= ctrl_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_target.sv
// tb_uart_tx_target: register vectors, line-waveform checks against a frame model, and randomized FIFO/divisor runs
module tb_uart_tx_target;
    logic clk = 1'b0;
    logic rst, wen, ren;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic sel, tx, irq;
    int tests = 0;
    int fails = 0;
    bit rec = 1'b0;
    bit line[$];
    bit exp_line[$];

    typedef struct {
        logic        wen;
        logic        ren;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        sel;
    } vec_t;
    vec_t vt[22];

    uart_tx_target dut (
        .clk(clk), .rst(rst), .wen(wen), .ren(ren), .addr(addr), .wdata(wdata),
        .rdata(rdata), .sel(sel), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (rec) line.push_back(tx);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        wen = 1'b1;
        addr = a;
        wdata = d;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        ren = 1'b1;
        addr = a;
        #1;
        d = rdata;
        ren = 1'b0;
    endtask

    task automatic status(output logic [31:0] s);
        rd(16'hF004, s);
    endtask

    task automatic wait_status(input logic [31:0] mask, input logic [31:0] val, input int budget, output int bc);
        logic [31:0] s;
        int n;
        bc = 0;
        n = 0;
        status(s);
        while ((s & mask) !== val && n < budget) begin
            @(negedge clk);
            status(s);
            bc += int'(s[0]);
            n++;
        end
        chk("wait_status", s & mask, val);
    endtask

    task automatic wait_fall(input int budget);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("tx_fall", 32'(tx), 32'h0);
    endtask

    task automatic add_frame(input logic [7:0] b, input int l0, input int ln);
        repeat (l0) exp_line.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (ln) exp_line.push_back(b[i]);
        repeat (ln) exp_line.push_back(1'b1);
    endtask

    task automatic add_idle(input int n);
        repeat (n) exp_line.push_back(1'b1);
    endtask

    task automatic start_rec();
        line.delete();
        exp_line.delete();
        rec = 1'b1;
    endtask

    task automatic check_line(input string nm);
        int i;
        int bad;
        i = 0;
        bad = -1;
        rec = 1'b0;
        while (i < line.size() && line[i]) i++;
        for (int k = 0; k < exp_line.size(); k++) begin
            if (i + k >= line.size() || line[i + k] !== exp_line[k]) begin
                bad = k;
                break;
            end
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s: line sample %0d of %0d differs (got %0d samples after start, expected %0d)",
                     nm, bad, exp_line.size(), line.size() - i, exp_line.size());
        end
    endtask

    initial begin
        logic [31:0] s;
        logic [7:0] b;
        logic [7:0] q[$];
        int bc, viol, d, n;
        bit seen, movf;
        rst = 1'b1;
        wen = 1'b0;
        ren = 1'b0;
        addr = '0;
        wdata = '0;
        vt[0]  = '{1'b0, 1'b1, 16'hF004, 32'h0, 32'h4, 1'b1};
        vt[1]  = '{1'b0, 1'b1, 16'hF008, 32'h0, 32'h67, 1'b1};
        vt[2]  = '{1'b0, 1'b1, 16'hF00C, 32'h0, 32'h0, 1'b1};
        vt[3]  = '{1'b0, 1'b1, 16'hF000, 32'h0, 32'h0, 1'b1};
        vt[4]  = '{1'b0, 1'b0, 16'hF008, 32'h0, 32'h0, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 16'hEFFF, 32'h0, 32'h0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 16'hF010, 32'h0, 32'h0, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 16'hF00A, 32'h0, 32'h0, 1'b1};
        vt[8]  = '{1'b1, 1'b0, 16'hF009, 32'h5, 32'h0, 1'b1};
        vt[9]  = '{1'b1, 1'b0, 16'hF018, 32'h7, 32'h0, 1'b0};
        vt[10] = '{1'b0, 1'b1, 16'hF008, 32'h0, 32'h67, 1'b1};
        vt[11] = '{1'b1, 1'b0, 16'hF001, 32'h41, 32'h0, 1'b1};
        vt[12] = '{1'b1, 1'b0, 16'hF010, 32'h99, 32'h0, 1'b0};
        vt[13] = '{1'b0, 1'b1, 16'hF004, 32'h0, 32'h4, 1'b1};
        vt[14] = '{1'b1, 1'b0, 16'hF008, 32'hABCD1234, 32'h0, 1'b1};
        vt[15] = '{1'b0, 1'b1, 16'hF008, 32'h0, 32'h1234, 1'b1};
        vt[16] = '{1'b1, 1'b1, 16'hF00C, 32'hFFFFFFFF, 32'h0, 1'b1};
        vt[17] = '{1'b0, 1'b1, 16'hF00C, 32'h0, 32'h3, 1'b1};
        vt[18] = '{1'b1, 1'b0, 16'hF00C, 32'h0, 32'h0, 1'b1};
        vt[19] = '{1'b0, 1'b1, 16'hF00C, 32'h0, 32'h0, 1'b1};
        vt[20] = '{1'b0, 1'b1, 16'hF00F, 32'h0, 32'h0, 1'b1};
        vt[21] = '{1'b0, 1'b1, 16'hF000, 32'h0, 32'h0, 1'b1};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_tx", 32'(tx), 32'h1);
        chk("reset_irq", 32'(irq), 32'h0);

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            wen = vt[i].wen;
            ren = vt[i].ren;
            addr = vt[i].addr;
            wdata = vt[i].wdata;
            #1;
            chk($sformatf("vec%0d_rdata", i), rdata, vt[i].rdata);
            chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(vt[i].sel));
            @(posedge clk);
            #1;
            wen = 1'b0;
            ren = 1'b0;
        end

        wr(16'hF008, 32'd3);
        wr(16'hF00C, 32'h1);
        start_rec();
        wr(16'hF000, 32'h55);
        chk("tx_before_start", 32'(tx), 32'h1);
        @(negedge clk);
        chk("tx_start_edge", 32'(tx), 32'h0);
        status(s);
        chk("busy_at_start", 32'(s[0]), 32'h1);
        wait_status(32'h5, 32'h4, 200, bc);
        chk("busy_cycles_div3", 32'(bc + 1), 32'd40);
        repeat (3) @(negedge clk);
        add_frame(8'h55, 4, 4);
        add_idle(3);
        check_line("frame_55_div3");

        wr(16'hF008, 32'd0);
        wr(16'hF00C, 32'h0);
        for (int i = 1; i <= 9; i++) wr(16'hF000, 32'(i));
        status(s);
        chk("status_full_ovf", s, 32'h0000080A);
        start_rec();
        wr(16'hF00C, 32'h1);
        wait_status(32'h5, 32'h4, 300, bc);
        chk("busy_cycles_8frames", 32'(bc), 32'd80);
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 8; i++) add_frame(8'(i), 1, 1);
        add_idle(3);
        check_line("frames_01_08_div0");
        status(s);
        chk("ovf_sticky", s, 32'h0000000C);
        wr(16'hF00C, 32'h5);
        status(s);
        chk("ovf_cleared", s, 32'h4);
        rd(16'hF00C, s);
        chk("ctrl_after_clr", s, 32'h1);

        wr(16'hF008, 32'd3);
        wr(16'hF00C, 32'h0);
        wr(16'hF000, 32'hA3);
        wr(16'hF000, 32'h3C);
        start_rec();
        wr(16'hF00C, 32'h1);
        wait_fall(50);
        repeat (12) @(negedge clk);
        wr(16'hF00C, 32'h0);
        wait_status(32'h1, 32'h0, 200, bc);
        repeat (10) @(negedge clk);
        status(s);
        chk("txen_off_level", s, 32'h00000100);
        add_frame(8'hA3, 4, 4);
        add_idle(10);
        check_line("txen_off_frame");
        wr(16'hF00C, 32'h1);
        wait_status(32'h5, 32'h4, 200, bc);

        wr(16'hF008, 32'd3);
        start_rec();
        wr(16'hF000, 32'h55);
        wait_fall(20);
        wr(16'hF008, 32'd1);
        wait_status(32'h5, 32'h4, 200, bc);
        repeat (3) @(negedge clk);
        add_frame(8'h55, 4, 2);
        add_idle(3);
        check_line("div_change_midbit");

        wr(16'hF008, 32'd1);
        wr(16'hF00C, 32'h2);
        @(negedge clk);
        chk("irq_idle_empty", 32'(irq), 32'h1);
        wr(16'hF000, 32'h11);
        wr(16'hF000, 32'h22);
        chk("irq_not_empty", 32'(irq), 32'h0);
        wr(16'hF00C, 32'h3);
        seen = 1'b0;
        viol = 0;
        n = 0;
        status(s);
        while (!(seen && !s[0]) && n < 200) begin
            if (s[0] && irq) viol++;
            seen |= s[0];
            @(negedge clk);
            status(s);
            n++;
        end
        chk("irq_busy_low", 32'(viol), 32'h0);
        chk("irq_done_wait", 32'(seen && !s[0]), 32'h1);
        chk("irq_at_stop_end", 32'(irq), 32'h0);
        @(negedge clk);
        chk("irq_after_stop", 32'(irq), 32'h1);

        wr(16'hF008, 32'd3);
        wr(16'hF000, 32'h77);
        wr(16'hF000, 32'h88);
        wr(16'hF000, 32'h99);
        repeat (6) @(negedge clk);
        status(s);
        chk("busy_before_rst", 32'(s[0]), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_tx", 32'(tx), 32'h1);
        chk("rst_irq", 32'(irq), 32'h0);
        status(s);
        chk("rst_status", s, 32'h4);
        rd(16'hF008, s);
        chk("rst_div", s, 32'h67);
        rd(16'hF00C, s);
        chk("rst_ctrl", s, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int it = 0; it < 6; it++) begin
            d = $urandom_range(0, 3);
            n = $urandom_range(1, 10);
            wr(16'hF00C, 32'h4);
            wr(16'hF008, 32'(d));
            q.delete();
            movf = 1'b0;
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                wr(16'hF000, {24'h0, b});
                if (q.size() < 8) q.push_back(b);
                else movf = 1'b1;
            end
            status(s);
            chk($sformatf("rand%0d_status", it), s,
                {16'h0, 8'(q.size()), 4'h0, movf, q.size() == 0, q.size() == 8, 1'b0});
            start_rec();
            foreach (q[k]) add_frame(q[k], d + 1, d + 1);
            add_idle(3);
            wr(16'hF00C, 32'h1);
            wait_status(32'h5, 32'h4, 500, bc);
            chk($sformatf("rand%0d_busy", it), 32'(bc), 32'(q.size() * 10 * (d + 1)));
            repeat (3) @(negedge clk);
            check_line($sformatf("rand%0d_line", it));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
